// File: rtl/bidir_io_port.sv
// Registered bidirectional I/O port: per-pad direction, guarded input->output turnaround,
// synchronised readback and sticky input-change flags with a registered interrupt.
module bidir_io_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] pad,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_data_en,
  input  logic [WIDTH-1:0] dir,
  input  logic             dir_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] change,
  input  logic [WIDTH-1:0] change_clr,
  output logic             irq,
  output logic             busy
);

  typedef enum logic {IDLE, TURN} state_t;

  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES);
  localparam logic [2:0] SETTLE_LOAD = 3'(SYNC_STAGES + 1);

  function automatic logic [3:0] dec_sat4(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  function automatic logic [2:0] dec_sat3(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  state_t           state;
  logic [3:0]       cnt;
  logic [2:0]       settle_cnt;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev_p;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] watch;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] new_bits;

  assign new_bits = dir & ~oe_q;

  // Output/direction control and the turnaround FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= 4'd0;
      settle_cnt <= 3'd0;
      out_q      <= '0;
      dir_q      <= '0;
      oe_q       <= '0;
    end else begin
      if (wr_data_en)
        out_q <= wr_data;

      if (dir_en) begin
        dir_q      <= dir;
        // Released bits drop at once; already-driving bits continue; new bits wait.
        oe_q       <= oe_q & dir;
        settle_cnt <= SETTLE_LOAD;
        if (|new_bits) begin
          state <= TURN;
          busy  <= 1'b1;
          cnt   <= TURN_LOAD;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= 4'd0;
        end
      end else begin
        settle_cnt <= dec_sat3(settle_cnt);
        if (state == TURN) begin
          if (cnt != 4'd0) begin
            cnt <= dec_sat4(cnt);
          end else begin
            oe_q  <= dir_q;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

  // Input synchroniser, stage 0 samples the pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_p[k] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= pad;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_p[k] <= sync_p[k-1];
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign sync_last = sync_p[SYNC_STAGES-1];
  assign rd_data   = sync_last;

  // Only true inputs outside the post-direction-change settle window may flag changes.
  assign watch    = ~dir_q & ~oe_q & {WIDTH{settle_cnt == 3'd0}};
  assign edge_hit = (sync_last ^ prev_p) & watch;

  // Change flags and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      change <= '0;
      irq    <= 1'b0;
    end else begin
      change <= (change & ~change_clr) | edge_hit;
      irq    <= |change;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad[i] = oe_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: tb/tb_bidir_io_port.sv
// Directed bench for bidir_io_port: a vector table for the main flow on a TURN_CYCLES=1
// instance, plus hand sequences for mid-turnaround reset and dir_en re-issue (TURN_CYCLES=3).
module tb_bidir_io_port;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n;
  wire  [7:0] pad_a, pad_b;
  logic [7:0] wr_a, dir_a, clr_a, wr_b, dir_b, clr_b;
  logic       wen_a, den_a, wen_b, den_b;
  logic [7:0] rd_a, chg_a, rd_b, chg_b;
  logic       irq_a, busy_a, irq_b, busy_b;
  logic [7:0] xoe_a, xval_a, xoe_b, xval_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pad_a[i] = xoe_a[i] ? xval_a[i] : 1'bz;
    assign pad_b[i] = xoe_b[i] ? xval_b[i] : 1'bz;
  end

  bidir_io_port #(.WIDTH(8), .SYNC_STAGES(2), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .reset_n(rst_a_n), .pad(pad_a), .wr_data(wr_a), .wr_data_en(wen_a),
    .dir(dir_a), .dir_en(den_a), .rd_data(rd_a), .change(chg_a), .change_clr(clr_a),
    .irq(irq_a), .busy(busy_a));

  bidir_io_port #(.WIDTH(8), .SYNC_STAGES(2), .TURN_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(rst_b_n), .pad(pad_b), .wr_data(wr_b), .wr_data_en(wen_b),
    .dir(dir_b), .dir_en(den_b), .rd_data(rd_b), .change(chg_b), .change_clr(clr_b),
    .irq(irq_b), .busy(busy_b));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // External pad drive (xoe/xval) is applied just after the edge, so it follows the DUT's
  // own drive changes without contention; the sampled pad value comes from the prior row.
  typedef struct {
    logic       wen;
    logic [7:0] wdata;
    logic       den;
    logic [7:0] dir;
    logic [7:0] clr;
    logic [7:0] xoe;
    logic [7:0] xval;
    logic [7:0] e_pad;
    logic [7:0] e_rd;
    logic       e_busy;
    logic [7:0] e_chg;
    logic       e_irq;
  } vec_t;

  vec_t vecs [23];

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'h05, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h10, 8'h15, 8'h05, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h10, 8'h15, 8'h05, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h10, 8'h15, 8'h15, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h10, 8'h15, 8'h15, 1'b0, 8'h10, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h15, 1'b0, 8'h10, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h15, 1'b0, 8'h10, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h10, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h10, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h10, 1'b1};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h10, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0};

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    wr_a = '0; dir_a = '0; clr_a = '0; wen_a = 1'b0; den_a = 1'b0;
    wr_b = '0; dir_b = '0; clr_b = '0; wen_b = 1'b0; den_b = 1'b0;
    xoe_a = 8'hFF; xval_a = 8'h00; xoe_b = 8'hFF; xval_b = 8'h00;

    #12;
    chk("reset rd_data", rd_a, 8'h00);
    chk("reset change", chg_a, 8'h00);
    chk("reset busy", {7'd0, busy_a}, 8'h00);
    chk("reset irq", {7'd0, irq_a}, 8'h00);
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    for (int r = 0; r < 23; r++) begin
      wen_a = vecs[r].wen; wr_a = vecs[r].wdata;
      den_a = vecs[r].den; dir_a = vecs[r].dir; clr_a = vecs[r].clr;
      @(posedge clk);
      #1;
      xoe_a = vecs[r].xoe; xval_a = vecs[r].xval;
      #1;
      chk($sformatf("row%0d pad", r), pad_a, vecs[r].e_pad);
      chk($sformatf("row%0d rd_data", r), rd_a, vecs[r].e_rd);
      chk($sformatf("row%0d busy", r), {7'd0, busy_a}, {7'd0, vecs[r].e_busy});
      chk($sformatf("row%0d change", r), chg_a, vecs[r].e_chg);
      chk($sformatf("row%0d irq", r), {7'd0, irq_a}, {7'd0, vecs[r].e_irq});
    end
    wen_a = 1'b0; den_a = 1'b0; clr_a = '0;

    // Reset in the middle of a turnaround while bits [3:0] are driving
    den_a = 1'b1; dir_a = 8'hFF;
    @(posedge clk); #2;
    den_a = 1'b0;
    chk("midturn busy", {7'd0, busy_a}, 8'h01);
    chk("midturn pad", pad_a, 8'h05);
    #2;
    xoe_a = 8'hFF; xval_a = 8'h00;
    rst_a_n = 1'b0;
    #1;
    chk("async reset pad", pad_a, 8'h00);
    chk("async reset busy", {7'd0, busy_a}, 8'h00);
    chk("async reset rd_data", rd_a, 8'h00);
    chk("async reset change", chg_a, 8'h00);
    chk("async reset irq", {7'd0, irq_a}, 8'h00);
    @(negedge clk);
    rst_a_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk($sformatf("abandoned turn pad e%0d", k), pad_a, 8'h00);
      chk($sformatf("abandoned turn busy e%0d", k), {7'd0, busy_a}, 8'h00);
    end

    // dir_en re-issued during TURN restarts the count (TURN_CYCLES=3)
    wen_b = 1'b1; wr_b = 8'hFF;
    @(posedge clk); #2;
    wen_b = 1'b0;
    den_b = 1'b1; dir_b = 8'h0F;
    @(posedge clk); #2;
    chk("reissue first busy", {7'd0, busy_b}, 8'h01);
    dir_b = 8'hFF;
    @(posedge clk); #2;
    den_b = 1'b0;
    chk("reissue e0 busy", {7'd0, busy_b}, 8'h01);
    chk("reissue e0 pad", pad_b, 8'h00);
    wen_b = 1'b1; wr_b = 8'h3C;
    @(posedge clk); #2;
    wen_b = 1'b0;
    chk("reissue e1 pad", pad_b, 8'h00);
    @(posedge clk); #2;
    chk("reissue e2 pad", pad_b, 8'h00);
    @(posedge clk); #2;
    chk("reissue e3 pad", pad_b, 8'h00);
    chk("reissue e3 busy", {7'd0, busy_b}, 8'h01);
    @(posedge clk); #1;
    xoe_b = 8'h00;
    #1;
    chk("reissue e4 pad", pad_b, 8'h3C);
    chk("reissue e4 busy", {7'd0, busy_b}, 8'h00);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("reissue readback", rd_b, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
